// File: rtl/cheat_loader_if.sv
// Wishbone master/slave bundle used by cheat_loader to reach the cheat data register.
interface cheat_loader_if;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [1:0]   addr;
    logic [128:0] data;
    logic         ack;
    logic         stall;
    logic         err;

    modport master (
        output cyc, stb, we, addr, data,
        input  ack, stall, err
    );

    modport slave (
        input  cyc, stb, we, addr, data,
        output ack, stall, err
    );
endinterface

// File: rtl/cheat_loader.sv
// Cheat record loader: assembles byte-stream records and writes legal ones to the
// cheat data register over Wishbone. Define CHEAT_LOADER_CHECKSUM_EN for 17-byte records with an XOR check byte.
module cheat_loader #(
    parameter int unsigned MAX_CHEATS  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_clear,
    input  logic [7:0]     i_rx_data,
    input  logic           i_rx_valid,
    output logic           o_rx_ready,
    output logic           o_cheats_loaded,
    output logic [7:0]     o_cheat_count,
    output logic           o_busy,
    output logic           o_err,
    cheat_loader_if.master wb
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        STROBE,
        WAIT_ACK
    } state_t;

    localparam int unsigned TW      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]  MAX_IDX = 8'(MAX_CHEATS);

`ifdef CHEAT_LOADER_CHECKSUM_EN
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_BYTE = 5'd16;
`else
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_BYTE = 4'd15;
`endif

    state_t          state_q;
    logic [CW-1:0]   byte_cnt_q;
    logic [127:0]    rec_q;
    logic [TW-1:0]   timer_q;
    logic            cyc_q;
    logic            stb_q;
    logic            rx_ready_q;
    logic            loaded_q;
    logic [7:0]      count_q;
    logic            err_q;

    logic            take;
    logic [7:0]      rec_idx;
    logic            sum_bad;
    logic            bus_ok;
    logic            bus_fail;

`ifdef CHEAT_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q;
    logic [7:0]      chk_q;
    assign sum_bad = (sum_q != chk_q);
`else
    assign sum_bad = 1'b0;
`endif

    assign take    = i_rx_valid && rx_ready_q;
    assign rec_idx = rec_q[111:104];

    // Ack is only honoured in STROBE once the slave stops stalling; timeout covers STROBE+WAIT_ACK.
    always_comb begin
        bus_ok   = 1'b0;
        bus_fail = 1'b0;
        if (state_q == STROBE || state_q == WAIT_ACK) begin
            bus_ok   = !wb.err && wb.ack && !(state_q == STROBE && wb.stall);
            bus_fail = wb.err || (!bus_ok && timer_q == T_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            rec_q      <= '0;
            timer_q    <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            loaded_q   <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
`ifdef CHEAT_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            chk_q      <= '0;
`endif
        end else if (i_clear) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            rx_ready_q <= 1'b1;
            loaded_q   <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    rx_ready_q <= 1'b1;
                    if (take) begin
`ifdef CHEAT_LOADER_CHECKSUM_EN
                        if (byte_cnt_q == LAST_BYTE) begin
                            chk_q <= i_rx_data;
                        end else begin
                            rec_q <= {rec_q[119:0], i_rx_data};
                            sum_q <= (byte_cnt_q == '0) ? i_rx_data : (sum_q ^ i_rx_data);
                        end
`else
                        rec_q <= {rec_q[119:0], i_rx_data};
`endif
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_q <= '0;
                            rx_ready_q <= 1'b0;
                            state_q    <= CHECK;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CW'(1);
                            state_q    <= COLLECT;
                        end
                    end
                end

                CHECK: begin
                    if (sum_bad || rec_idx > MAX_IDX) begin
                        err_q      <= 1'b1;
                        rx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else if (rec_idx == 8'd0) begin
                        loaded_q   <= 1'b1;
                        rx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= STROBE;
                    end
                end

                STROBE, WAIT_ACK: begin
                    if (bus_ok || bus_fail) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                        if (bus_ok) begin
                            if (count_q != 8'hFF) begin
                                count_q <= count_q + 8'd1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                        if (state_q == STROBE && !wb.stall) begin
                            stb_q   <= 1'b0;
                            state_q <= WAIT_ACK;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb.cyc          = cyc_q;
    assign wb.stb          = stb_q;
    assign wb.we           = cyc_q;
    assign wb.addr         = 2'h1;
    assign wb.data         = {1'b0, rec_q};

    assign o_rx_ready      = rx_ready_q;
    assign o_cheats_loaded = loaded_q;
    assign o_cheat_count   = count_q;
    assign o_busy          = cyc_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_cheat_loader.sv
// Directed and randomized checks of cheat_loader against a record-level reference model.
`timescale 1ns/1ps
module tb_cheat_loader;

    localparam int unsigned MAXC = 4;
    localparam int unsigned TMO  = 255;

    logic       i_clk      = 1'b0;
    logic       i_reset_n  = 1'b0;
    logic       i_clear    = 1'b0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_rx_data  = '0;
    logic       o_rx_ready;
    logic       o_cheats_loaded;
    logic       o_busy;
    logic       o_err;
    logic [7:0] o_cheat_count;

    cheat_loader_if wb_bus ();

    cheat_loader #(
        .MAX_CHEATS (MAXC),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_clear        (i_clear),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_rx_ready     (o_rx_ready),
        .o_cheats_loaded(o_cheats_loaded),
        .o_cheat_count  (o_cheat_count),
        .o_busy         (o_busy),
        .o_err          (o_err),
        .wb             (wb_bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs: stall cycles before accept, ack latency after accept, 0=ack 1=silent 2=err.
    int cfg_stall = 0;
    int cfg_lat   = 0;
    int cfg_mode  = 0;

    int           stall_left = 0;
    int           ack_wait   = 0;
    bit           accepted   = 0;
    bit           first_seen = 0;
    int           cyc_cycles = 0;
    int           stb_cycles = 0;
    bit           data_moved = 0;
    logic [128:0] data_first = '0;
    logic [128:0] wr_q[$];
    logic [128:0] exp_q[$];

    int exp_count  = 0;
    bit exp_loaded = 0;
    bit exp_err    = 0;

    initial begin
        wb_bus.ack   = 1'b0;
        wb_bus.stall = 1'b0;
        wb_bus.err   = 1'b0;
    end

    always @(negedge i_clk) begin
        bit respond;
        respond      = 0;
        wb_bus.ack   = 1'b0;
        wb_bus.err   = 1'b0;
        wb_bus.stall = 1'b0;
        if (wb_bus.cyc !== 1'b1) begin
            accepted   = 0;
            first_seen = 0;
            stall_left = cfg_stall;
            ack_wait   = cfg_lat;
        end else begin
            cyc_cycles++;
            if (wb_bus.stb === 1'b1) stb_cycles++;
            if (!first_seen) begin
                data_first = wb_bus.data;
                first_seen = 1;
            end else if (wb_bus.data !== data_first) begin
                data_moved = 1;
            end
            if (!accepted) begin
                if (stall_left > 0) begin
                    wb_bus.stall = 1'b1;
                    stall_left--;
                end else begin
                    accepted = 1;
                    respond  = (ack_wait == 0);
                end
            end else if (ack_wait > 0) begin
                ack_wait--;
                respond = (ack_wait == 0);
            end
            if (respond) begin
                if (cfg_mode == 0) begin
                    wb_bus.ack = 1'b1;
                    wr_q.push_back(wb_bus.data);
                end else if (cfg_mode == 2) begin
                    wb_bus.err = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] idx, input logic cen,
                                          input logic [15:0] addr, input logic [7:0] cmp,
                                          input logic [7:0] repl);
        return (128'(idx) << 104) | (128'(cen) << 96) | (128'(addr) << 64) |
               (128'(cmp) << 32) | 128'(repl);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (o_rx_ready !== 1'b1 && n < 100) begin
            i_rx_valid = 1'b0;
            @(negedge i_clk);
            n++;
        end
        if (o_rx_ready !== 1'b1) begin
            check("rx_ready_wait", o_rx_ready, 1);
            return;
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge i_clk);
        while (wb_bus.cyc === 1'b1 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check("bus_released", wb_bus.cyc, 0);
        @(negedge i_clk);
    endtask

    // Reference model: outcome of one record decided from its index, checksum and the slave's answer.
    task automatic run_record(input logic [127:0] rec, input bit bad_sum, input bit wait_done);
        logic [7:0] idx;
`ifdef CHEAT_LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        idx = rec[111:104];
        if (bad_sum) exp_err = 1;
        else if (idx == 8'd0) exp_loaded = 1;
        else if (idx > 8'(MAXC)) exp_err = 1;
        else if (cfg_mode == 0) begin
            exp_q.push_back({1'b0, rec});
            if (exp_count < 255) exp_count++;
        end else exp_err = 1;
        for (int i = 15; i >= 0; i--) begin
            send_byte(rec[i*8 +: 8]);
`ifdef CHEAT_LOADER_CHECKSUM_EN
            sum = sum ^ rec[i*8 +: 8];
`endif
        end
`ifdef CHEAT_LOADER_CHECKSUM_EN
        send_byte(bad_sum ? ~sum : sum);
`endif
        i_rx_valid = 1'b0;
        if (wait_done) wait_idle();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, o_cheat_count, exp_count);
        check({tag, "_loaded"}, o_cheats_loaded, exp_loaded);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        while (wr_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wdata"}, wr_q.pop_front(), exp_q.pop_front());
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic model_zero();
        exp_count  = 0;
        exp_loaded = 0;
        exp_err    = 0;
        exp_q.delete();
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        model_zero();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rec;

        repeat (3) @(negedge i_clk);
        check("rst_rx_ready", o_rx_ready, 0);
        check("rst_cyc", wb_bus.cyc, 0);
        check("rst_stb", wb_bus.stb, 0);
        check("rst_we", wb_bus.we, 0);
        check("rst_addr", wb_bus.addr, 2'h1);
        check("rst_data", wb_bus.data, 0);
        check("rst_count", o_cheat_count, 0);
        check("rst_loaded", o_cheats_loaded, 0);
        check("rst_err", o_err, 0);
        check("rst_busy", o_busy, 0);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_reset", o_rx_ready, 1);

        // Basic write, index 1, no stall.
        cfg_stall = 0; cfg_lat = 1; cfg_mode = 0; stb_cycles = 0;
        run_record(pack(8'd1, 1'b1, 16'h23A2, 8'hD6, 8'h24), 0, 1);
        check("basic_stb_cycles", stb_cycles, 1);
        check_state("basic");

        // Stall for 3 cycles, ack in the accepting cycle.
        cfg_stall = 3; cfg_lat = 0; stb_cycles = 0; data_moved = 0;
        run_record(pack(8'd1, 1'b1, 16'h23A2, 8'hD6, 8'h24), 0, 1);
        check("stall_stb_cycles", stb_cycles, 4);
        check("stall_data_stable", data_moved, 0);
        check_state("stall");

        // Out-of-range index never opens a bus cycle.
        cfg_stall = 0; cfg_lat = 1; cyc_cycles = 0;
        run_record(pack(8'd5, 1'b0, 16'h1000, 8'h00, 8'h11), 0, 1);
        check("badidx_no_cyc", cyc_cycles, 0);
        check_state("badidx");
        do_clear();
        check_state("clear1");

        // Four writes then end-of-list, then one more write after loaded.
        for (int k = 1; k <= 4; k++)
            run_record(pack(8'(k), 1'b0, 16'(k * 16'h0101), 8'(k), 8'(k + 8'h40)), 0, 1);
        run_record(pack(8'd0, 1'b0, 16'h0000, 8'h00, 8'h00), 0, 1);
        check_state("list");
        run_record(pack(8'd4, 1'b1, 16'hBEEF, 8'h12, 8'h34), 0, 1);
        check_state("after_loaded");

        // Error responses in WAIT_ACK and in STROBE.
        cfg_mode = 2; cfg_lat = 2;
        run_record(pack(8'd2, 1'b0, 16'h0042, 8'h00, 8'h77), 0, 1);
        check_state("err_waitack");
        cfg_lat = 0;
        run_record(pack(8'd3, 1'b0, 16'h0043, 8'h00, 8'h78), 0, 1);
        check_state("err_strobe");
        do_clear();

        // Silent slave times out.
        cfg_mode = 1; cfg_stall = 0; cyc_cycles = 0;
        run_record(pack(8'd1, 1'b0, 16'h5555, 8'h00, 8'h01), 0, 1);
        check("timeout_cycles", cyc_cycles, TMO);
        check_state("timeout");
        do_clear();
        check_state("timeout_clear");

        // Clear while a cycle is open.
        cfg_mode = 1;
        run_record(pack(8'd2, 1'b0, 16'h6666, 8'h00, 8'h02), 0, 0);
        repeat (5) @(negedge i_clk);
        check("midcyc_busy", o_busy, 1);
        check("midcyc_rx_ready", o_rx_ready, 0);
        check("midcyc_stb", wb_bus.stb, 0);
        do_clear();
        check("clear_cyc", wb_bus.cyc, 0);
        check("clear_stb", wb_bus.stb, 0);
        @(negedge i_clk);
        check_state("midcyc_clear");

        // Reset in the middle of a record discards the partial bytes.
        cfg_mode = 0; cfg_lat = 0;
        for (int k = 0; k < 7; k++) send_byte(8'($urandom));
        i_rx_valid = 1'b0;
        #2 i_reset_n = 1'b0;
        #1 check("rst_midrec_ready", o_rx_ready, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_zero();
        run_record(pack(8'd3, 1'b1, 16'hA5A5, 8'h5A, 8'hC3), 0, 1);
        check_state("rst_midrec");

        // Reset while a cycle waits for a late ack.
        cfg_lat = 20;
        run_record(pack(8'd1, 1'b0, 16'h0101, 8'h00, 8'h09), 0, 0);
        repeat (4) @(negedge i_clk);
        check("rst_midcyc_busy", o_busy, 1);
        #2 i_reset_n = 1'b0;
        #1 check("rst_midcyc_cyc", wb_bus.cyc, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        model_zero();
        repeat (30) @(negedge i_clk);
        check_state("rst_midcyc");

        // Randomized records.
        for (int r = 0; r < 24; r++) begin
            rec = {$urandom, $urandom, $urandom, $urandom};
            rec[111:104] = 8'($urandom_range(0, 6));
            cfg_stall = $urandom_range(0, 2);
            cfg_lat   = $urandom_range(0, 3);
            cfg_mode  = ($urandom_range(0, 9) == 0) ? 2 : 0;
            run_record(rec, 0, 1);
            check_state("rand");
            if (exp_err && $urandom_range(0, 2) == 0) do_clear();
        end

`ifdef CHEAT_LOADER_CHECKSUM_EN
        do_clear();
        cfg_stall = 0; cfg_lat = 0; cfg_mode = 0;
        run_record(pack(8'd2, 1'b1, 16'h1234, 8'h56, 8'h78), 1, 1);
        check_state("sum_bad");
        run_record(pack(8'd2, 1'b1, 16'h1234, 8'h56, 8'h78), 0, 1);
        check_state("sum_good");
`endif

        // Count saturates at 255.
        do_clear();
        cfg_stall = 0; cfg_lat = 0; cfg_mode = 0;
        for (int r = 0; r < 256; r++)
            run_record(pack(8'd1, 1'b0, 16'(r), 8'h00, 8'(r)), 0, 1);
        check_state("saturate");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
